// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// ps2_pkg: shared definitions for the PS/2 scancode receiver.
//   - ps2_state_e      : frame receiver state encoding
//   - PS2_BREAK/PS2_EXT: break (F0) and extended (E0) prefix bytes
//   - *_DEF            : parameter defaults for ps2_scan_rx
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int unsigned FILTER_LEN_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/ps2_scan_rx_if.sv
`timescale 1ns/1ps
// ps2_scan_rx_if: keyboard-side lines plus decoded-scancode outputs.
//   master : drives ps2_clk/ps2_data, observes the decoded outputs
//   slave  : the receiver, consumes ps2 lines, drives decoded outputs
interface ps2_scan_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       released;
  logic       extended;
  logic       valid;
  logic       err;

  modport master (
    output ps2_clk, ps2_data,
    input  code, released, extended, valid, err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output code, released, extended, valid, err
  );
endinterface

// File: rtl/ps2_sync_filter.sv
`timescale 1ns/1ps
// ps2_sync_filter: two-flop synchronizers on ps2_clk/ps2_data, a glitch
// filter on the clock, and filtered-clock falling-edge detection.
//   clk, rst_n : system clock, async active-low reset (lines preload to 1)
//   ps2_clk    : raw PS/2 clock      ps2_data : raw PS/2 data
//   fall_edge  : one-cycle pulse on a filtered ps2_clk 1->0 transition
//   data_s     : synchronized ps2_data
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_edge,
  output logic data_s
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Level flips only after FILTER_LEN consecutive samples disagreeing with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  assign fall_edge = filt_prev_q & ~filt_q;
  assign data_s    = data_sync_q;
endmodule

// File: rtl/ps2_scan_rx.sv
`timescale 1ns/1ps
// ps2_scan_rx: PS/2 keyboard scancode receiver (start, 8 data LSB first,
// odd parity, stop). Optional break/extended prefix decoding is enabled by
// defining PS2_BREAK_DECODE_EN; otherwise every good byte is delivered raw.
//   clk, reset         : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 lines
//   code               : last delivered byte
//   released, extended : break / E0 qualifiers of code
//   valid              : one-cycle strobe, new code delivered
//   err                : one-cycle strobe, frame discarded
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       released,
  output logic       extended,
  output logic       valid,
  output logic       err
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall_edge, data_s;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk      (clk),
    .rst_n    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall_edge(fall_edge),
    .data_s   (data_s)
  );

  ps2_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d, code_q, code_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          par_q, par_d;
  logic          released_q, released_d, extended_q, extended_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          pend_brk_q, pend_brk_d, pend_ext_q, pend_ext_d;
  logic          timeout, frame_ok;

  // An edge restarts the idle count, so timeout never coincides with one.
  assign timeout  = (state_q != IDLE) && !fall_edge && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok = (^shift_q ^ par_q) && data_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      par_q      <= 1'b0;
      code_q     <= '0;
      released_q <= 1'b0;
      extended_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      pend_brk_q <= 1'b0;
      pend_ext_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      par_q      <= par_d;
      code_q     <= code_d;
      released_q <= released_d;
      extended_q <= extended_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      pend_brk_q <= pend_brk_d;
      pend_ext_q <= pend_ext_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall_edge && !data_s) state_d = DATA;
      DATA:    if (fall_edge && bit_cnt_q == 3'd7) state_d = PARITY;
      PARITY:  if (fall_edge) state_d = STOP;
      STOP:    if (fall_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Prefix flags exist in both builds; only the decode build ever sets them,
  // so the raw build delivers released/extended as 0 through the same path.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    code_d     = code_q;
    released_d = released_q;
    extended_d = extended_q;
    pend_brk_d = pend_brk_q;
    pend_ext_d = pend_ext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    tmo_d      = (state_q == IDLE || fall_edge) ? '0 : tmo_q + TW'(1);

    if (fall_edge) begin
      unique case (state_q)
        IDLE: begin
          shift_d   = '0;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: par_d = data_s;
        STOP: begin
          if (!frame_ok) begin
            err_d      = 1'b1;
            pend_brk_d = 1'b0;
            pend_ext_d = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
          end else if (shift_q == PS2_BREAK) begin
            pend_brk_d = 1'b1;
          end else if (shift_q == PS2_EXT) begin
            pend_ext_d = 1'b1;
`endif
          end else begin
            valid_d    = 1'b1;
            code_d     = shift_q;
            released_d = pend_brk_q;
            extended_d = pend_ext_q;
            pend_brk_d = 1'b0;
            pend_ext_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (timeout) begin
      err_d      = 1'b1;
      shift_d    = '0;
      bit_cnt_d  = '0;
      tmo_d      = '0;
      pend_brk_d = 1'b0;
      pend_ext_d = 1'b0;
    end
  end

  assign code     = code_q;
  assign released = released_q;
  assign extended = extended_q;
  assign valid    = valid_q;
  assign err      = err_q;
endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal synchronized samples needed before the filtered ps2_clk level changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning clk cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock and all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 SHALL have port code  output  8  last delivered scancode byte.
REQ-008 SHALL have port released  output  1  code is a key-release (break) event.
REQ-009 SHALL have port extended  output  1  code carried an E0 prefix.
REQ-010 SHALL have port valid  output  1  one-cycle strobe: code/released/extended are new.
REQ-011 SHALL have port err  output  1  one-cycle strobe: frame discarded (parity, start, stop or timeout).

Function
REQ-012 SHALL pass ps2_clk and ps2_data through two flip-flops each before any use.
REQ-013 SHALL change the filtered clock level only after FILTER_LEN consecutive equal synchronized samples; shorter pulses are ignored.
REQ-014 SHALL sample synchronized ps2_data on the cycle a filtered ps2_clk falling edge is detected.
REQ-015 SHALL implement states IDLE, DATA, PARITY, STOP; IDLE->DATA on an edge with data=0; an edge with data=1 in IDLE is ignored with no err.
REQ-016 SHALL shift 8 data bits LSB first in DATA, then go to PARITY, then STOP, then IDLE.
REQ-017 SHALL accept a frame only if the XOR of the 8 data bits and the parity bit is 1 (odd parity) and the stop bit is 1; otherwise it SHALL pulse err and deliver nothing.
REQ-018 SHALL assert valid or err exactly one cycle, on the cycle after the stop-bit edge is detected.
REQ-019 SHALL hold code/released/extended stable between valid strobes.
REQ-020 SHALL count cycles since the last filtered edge outside IDLE; on reaching TIMEOUT_CYCLES it SHALL pulse err, clear the shift register and return to IDLE.
REQ-021 SHALL never assert valid and err in the same cycle.

Reset
REQ-022 SHALL, while reset is low, force state IDLE, code=8'h00, released=0, extended=0, valid=0, err=0, clear the counters, clear the prefix flags, and preload the filter and synchronizers with 1 (bus idle).
REQ-023 SHALL discard any partial frame on reset mid-frame without a valid or err pulse, then receive the next full frame normally.

Configuration
REQ-024 SHALL, with PS2_BREAK_DECODE_EN defined, treat a good F0 byte as setting a pending-break flag and E0 as setting a pending-extended flag, with no valid.
REQ-025 SHALL, in that mode, deliver the next non-prefix good byte with released and extended equal to the pending flags, then clear both.
REQ-026 SHALL, in that mode, clear the pending flags on err.
REQ-027 SHALL, without PS2_BREAK_DECODE_EN, deliver every good byte, including F0 and E0, as valid with released=0 and extended=0.

Structure
REQ-028 SHALL take the state enum, the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, and the parameter defaults from the shared package ps2_pkg.
REQ-029 SHALL put synchronizers, glitch filter and falling-edge detect in the sub-module ps2_sync_filter, whose outputs are fall_edge and data_s.

Verification
REQ-030 SHALL cover: frame 8'h1A with 40-clk low / 40-clk high PS/2 phases -> single valid, code=1A, released=0, extended=0, err never high.
REQ-031 SHALL cover, with PS2_BREAK_DECODE_EN: F0 then 1A -> no valid after F0; one valid with code=1A, released=1; and E0 F0 75 -> code=75, released=1, extended=1.
REQ-032 SHALL cover: 2C sent with inverted parity -> err pulse, no valid; a following 1A frame -> valid, code=1A.
REQ-033 SHALL cover: start bit and 4 data bits, then bus idle for TIMEOUT_CYCLES+10 -> one err pulse; a following 2C frame -> valid, code=2C.
REQ-034 SHALL cover: a 2-clk low glitch on ps2_clk in IDLE -> no state change, no strobe; reset pulsed mid-frame -> outputs at reset values, next 1A decoded correctly.
